// File: rtl/packet_queue_mc.sv
// packet_queue_mc: NUM_CH independent circular packet buffers, drained by a
// round-robin arbiter into one registered valid/ready output port.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : producer handshake; in_ch selects the target channel
//   in_id..in_payload  : packet fields
//   flush[NUM_CH]      : per-channel discard of stored packets
//   out_valid/out_ready: consumer handshake; out_ch names the source channel
//   out_id..out_payload: registered packet fields
//   ch_empty/ch_full   : per-channel storage status
//   ch_count           : per-channel occupancy, channel i at [i*CNT_W +: CNT_W]

// Per-channel storage: circular buffer with count. The parent guarantees
// push never hits a full channel and pop never hits an empty one.
module packet_queue_mc_ch #(
  parameter int DEPTH = 16,
  parameter int PKT_W = 192,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [PKT_W-1:0] wdata_i,
  output logic [PKT_W-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

module packet_queue_mc #(
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 16,
  parameter int ID_W      = 32,
  parameter int ADDR_W    = 16,
  parameter int PAYLOAD_W = 128,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH_W-1:0]         in_ch,
  input  logic [ID_W-1:0]         in_id,
  input  logic [ADDR_W-1:0]       in_src,
  input  logic [ADDR_W-1:0]       in_dest,
  input  logic [PAYLOAD_W-1:0]    in_payload,
  input  logic [NUM_CH-1:0]       flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch,
  output logic [ID_W-1:0]         out_id,
  output logic [ADDR_W-1:0]       out_src,
  output logic [ADDR_W-1:0]       out_dest,
  output logic [PAYLOAD_W-1:0]    out_payload,
  output logic [NUM_CH-1:0]       ch_empty,
  output logic [NUM_CH-1:0]       ch_full,
  output logic [NUM_CH*CNT_W-1:0] ch_count
);
  localparam int PKT_W = ID_W + 2*ADDR_W + PAYLOAD_W;

  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic [NUM_CH-1:0][PKT_W-1:0] rdata;
  logic [NUM_CH-1:0]            push_vec, pop_vec, elig;
  logic [PKT_W-1:0]             wdata;
  logic                         load, gnt_vld;
  logic [CH_W-1:0]              gnt_ch;
  int                           idx;

  logic                 out_valid_q;
  logic [CH_W-1:0]      out_ch_q, rr_q, rr_d;
  logic [PKT_W-1:0]     out_pkt_q;

  assign wdata    = {in_id, in_src, in_dest, in_payload};
  assign in_ready = !rst && (int'(in_ch) < NUM_CH) && !ch_full[in_ch] && !flush[in_ch];
  assign load     = !out_valid_q || out_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign push_vec[i] = in_valid && in_ready && (in_ch == CH_W'(i));
    assign pop_vec[i]  = load && gnt_vld && (gnt_ch == CH_W'(i));
    assign elig[i]     = (cnt[i] != '0) && !flush[i];
    assign ch_empty[i] = (cnt[i] == '0);
    assign ch_full[i]  = (cnt[i] == CNT_W'(DEPTH));
    assign ch_count[i*CNT_W +: CNT_W] = cnt[i];

    packet_queue_mc_ch #(.DEPTH(DEPTH), .PKT_W(PKT_W), .CNT_W(CNT_W)) u_ch (
      .clk_i  (clk),
      .rst_i  (rst),
      .push_i (push_vec[i]),
      .pop_i  (pop_vec[i]),
      .flush_i(flush[i]),
      .wdata_i(wdata),
      .rdata_o(rdata[i]),
      .count_o(cnt[i])
    );
  end

  // Round-robin search starting at rr_q, wrapping at NUM_CH.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (load && gnt_vld)
      rr_d = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_pkt_q   <= '0;
      rr_q        <= '0;
    end else begin
      rr_q <= rr_d;
      if (load) begin
        // With nothing eligible the fields hold; only valid drops.
        out_valid_q <= gnt_vld;
        if (gnt_vld) begin
          out_ch_q  <= gnt_ch;
          out_pkt_q <= rdata[gnt_ch];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign {out_id, out_src, out_dest, out_payload} = out_pkt_q;
endmodule

// File: doc/packet_queue_mc.md
# packet_queue_mc

Multi-channel packet queue: the parametrised, synthesizable successor to the single-queue packet store. NUM_CH independent circular buffers each hold up to DEPTH packets with fixed-width id/src/dest/payload fields. A round-robin arbiter drains the non-empty channels into one registered valid/ready output port. The block sits between packet producers and the downstream router, and adds per-channel flush and occupancy reporting.

## Interface
- NUM_CH, 4: number of channels, ≥1
- DEPTH, 16: packets per channel, power of 2, ≥2
- ID_W, 32: id field width
- ADDR_W, 16: src/dest field width
- PAYLOAD_W, 128: payload width
- Derived: CH_W = (NUM_CH>1) ? $clog2(NUM_CH) : 1; CNT_W = $clog2(DEPTH+1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset: synchronous and active-high
- in_valid  in  1  producer offers packet
- in_ready  out  1  channel in_ch can accept
- in_ch  in  CH_W  target channel
- in_id / in_src / in_dest / in_payload  in  ID_W / ADDR_W / ADDR_W / PAYLOAD_W  packet fields
- flush  in  NUM_CH  per-channel discard
- out_valid  out  1  output register holds packet
- out_ready  in  1  consumer accepts
- out_ch  out  CH_W  source channel of output packet
- out_id / out_src / out_dest / out_payload  out  as inputs  packet fields
- ch_empty  out  NUM_CH  channel i storage empty
- ch_full  out  NUM_CH  channel i storage holds DEPTH
- ch_count  out  NUM_CH*CNT_W  channel i occupancy at [i*CNT_W +: CNT_W]

## Operation
- Per channel: wr_ptr, rd_ptr (log2 DEPTH bits, natural wrap), count (CNT_W bits). Storage is a memory array, not a dynamic queue.
- Accept rules:
  - in_ready = !rst && !ch_full[in_ch] && !flush[in_ch], combinational.
  - A push occurs when in_valid && in_ready: write at wr_ptr, wr_ptr+1, count+1.
  - No write-through when full, even if the channel is popped the same cycle.
- Output register load:
  - load = !out_valid || out_ready.
  - On load, the arbiter picks a channel with count>0 and no flush this cycle, pops its rd_ptr entry into out_*, sets out_ch, and sets out_valid=1.
  - If no channel is eligible on load, out_valid becomes 0 and out_* hold their previous value.
- Arbiter:
  - rr_ptr (CH_W bits, reset 0) is the highest-priority channel; search order is rr_ptr, rr_ptr+1, … with wrap at NUM_CH.
  - On grant g: rr_ptr <= (g+1) mod NUM_CH.
  - rr_ptr is unchanged when nothing is granted.
- Push and pop on the same channel in the same cycle: count unchanged, both pointers advance.
- Flush:
  - flush[i] zeroes wr_ptr, rd_ptr and count of channel i.
  - No push to or pop from channel i occurs that cycle.
  - A packet already in the output register is unaffected.
  - Other channels are unaffected.
- ch_empty[i] = (count==0); ch_full[i] = (count==DEPTH). ch_count reports storage only; it excludes the output register.
- Ordering: FIFO within a channel. No ordering across channels except round-robin.

## Timing
- Reset, while rst=1 at an edge:
  - All pointers and counts go to 0; rr_ptr=0.
  - out_valid=0; out_ch, out_id, out_src, out_dest, out_payload go to 0.
  - Memory contents are not reset.
- After reset: ch_empty all 1, ch_full all 0, ch_count all 0. in_ready=1 once rst=0.
- Reset mid-operation discards all stored packets and the output register packet. No partial state survives.
- Latency:
  - A packet accepted at edge T (empty channel, empty output register) is visible as count=1 in cycle T+1.
  - It is loaded at edge T+1, so out_valid=1 with its fields in cycle T+2.
- Throughput: with out_ready held at 1, one packet per cycle leaves while any channel is non-empty.
- Output stability: out_* hold stable while out_valid && !out_ready.
- Occupancy capacity: a channel blocked only by out_ready=0 holds DEPTH packets in storage plus at most one in the output register (block-wide).

## Test plan
- Reset: assert rst for 3 cycles mid-traffic, then release.
  - Expect out_valid=0, all out_* =0, ch_empty=4'b1111, ch_count all 0, in_ready=1 in the first cycle after release.
- Single packet: push ch2, id=0x11, src=0xA, dest=0xB, payload=128'hDEAD at edge T.
  - Expect out_valid=1, out_ch=2, fields equal to the inputs, in cycle T+2.
  - With out_ready=1, out_valid=0 the next cycle and ch_empty[2]=1.
- Full: out_ready=0, push 17 packets to ch0 with id 0..16.
  - Expect ch_count[0]=16, ch_full[0]=1, in_ready=0 for in_ch=0; an 18th in_valid is not accepted.
  - Raise out_ready: ids 0..16 leave in order.
- Round robin: out_ready=0; push ch0 {a,b}, ch1 {c,d}, ch3 {e,f}, with a pushed first.
  - Raise out_ready: output order a,c,e,b,d,f with out_ch 0,1,3,0,1,3.
- Flush: ch1 holds 3 packets and ch0 holds 2; in one cycle assert flush[1] and push to ch1.
  - Expect in_ready=0 and ch_count[1]=0 next cycle, ch_count[0]=2 unchanged; drained output contains only ch0 packets.
- Wrap: out_ready=1, stream ids 0..39 into ch2 with random in_valid gaps.
  - Expect all 40 out in order on out_ch=2, no loss or duplication, ch_count[2] never >16, ch_empty[2]=1 at end.
